// File: rtl/peribus_if.sv
// Peribus arbiter bundle: requester-side request/ack signals plus the shared peripheral port.
`timescale 1ns/1ps
interface peribus_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 8
);
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*16-1:0]     m_wdata;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS-1:0]        m_re;
  logic [N_MASTERS-1:0]        m_ack;
  logic [15:0]                 m_rdata;
  logic [ADDR_W-1:0]           s_addr;
  logic [15:0]                 s_write_data;
  logic                        s_write_en;
  logic                        s_read_en;
  logic [15:0]                 s_read_data;
  logic [1:0]                  grant_id;

  // Environment side: requesting masters and the peripheral.
  modport master (
    output m_req, m_addr, m_wdata, m_we, m_re, s_read_data,
    input  m_ack, m_rdata, s_addr, s_write_data, s_write_en, s_read_en, grant_id
  );

  // Arbiter side.
  modport slave (
    input  m_req, m_addr, m_wdata, m_we, m_re, s_read_data,
    output m_ack, m_rdata, s_addr, s_write_data, s_write_en, s_read_en, grant_id
  );
endinterface

// File: rtl/peribus_arbiter.sv
// Round-robin arbiter serialising single-beat Peribus transactions from N_MASTERS
// requesters onto one peripheral port; fixed 4-cycle IDLE/ISSUE/WAIT/ACK sequence.
`timescale 1ns/1ps
module peribus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 8
) (
  input logic     clock,
  input logic     reset_n,
  peribus_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic [1:0]           grant_q;
  logic                 is_read;
  logic [N_MASTERS-1:0] ack_q;
  logic [15:0]          rdata_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [15:0]          wdata_q;
  logic                 wen_q;
  logic                 ren_q;

  logic                 hi_valid, any_req;
  logic [1:0]           hi_idx, lo_idx, winner, ptr_next;
  logic [ADDR_W-1:0]    sel_addr;
  logic [15:0]          sel_wdata;
  logic                 sel_we, sel_re;
  logic [N_MASTERS-1:0] ack_onehot;

  // Two-pass priority: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    hi_valid   = 1'b0;
    hi_idx     = '0;
    any_req    = 1'b0;
    lo_idx     = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_we     = 1'b0;
    sel_re     = 1'b0;
    ack_onehot = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_req[i]) begin
        any_req = 1'b1;
        lo_idx  = 2'(i);
        if (2'(i) >= ptr) begin
          hi_valid = 1'b1;
          hi_idx   = 2'(i);
        end
      end
    end
    winner   = hi_valid ? hi_idx : lo_idx;
    ptr_next = (winner == 2'(N_MASTERS - 1)) ? 2'd0 : winner + 2'd1;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (2'(i) == winner) begin
        sel_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.m_wdata[i*16 +: 16];
        sel_we    = bus.m_we[i];
        sel_re    = bus.m_re[i];
      end
      ack_onehot[i] = (2'(i) == grant_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      is_read <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= '0;
          if (any_req) begin
            grant_q <= winner;
            ptr     <= ptr_next;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wen_q   <= sel_we;
            // Write wins when both we and re are set.
            ren_q   <= sel_re & ~sel_we;
            is_read <= sel_re & ~sel_we;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wen_q <= 1'b0;
          ren_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (is_read) rdata_q <= bus.s_read_data;
          ack_q <= ack_onehot;
          state <= ACK;
        end
        ACK: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_ack        = ack_q;
  assign bus.m_rdata      = rdata_q;
  assign bus.s_addr       = addr_q;
  assign bus.s_write_data = wdata_q;
  assign bus.s_write_en   = wen_q;
  assign bus.s_read_en    = ren_q;
  assign bus.grant_id     = grant_q;

endmodule

// File: tb/tb_peribus_arbiter.sv
// Directed bench: vector table for single transactions on a 2-master arbiter, plus
// hand sequences for reset abort, continuous contention and 3-master pointer wrap.
`timescale 1ns/1ps
module tb_peribus_arbiter;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  peribus_if #(.N_MASTERS(2), .ADDR_W(8)) bus_a ();
  peribus_if #(.N_MASTERS(3), .ADDR_W(8)) bus_b ();

  peribus_arbiter #(.N_MASTERS(2), .ADDR_W(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
  peribus_arbiter #(.N_MASTERS(3), .ADDR_W(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Peripheral model: registered read data = 0x1233 + addr, one cycle after the strobe.
  always @(posedge clock) begin
    if (bus_a.s_read_en) bus_a.s_read_data <= 16'h1233 + {8'h00, bus_a.s_addr};
    if (bus_b.s_read_en) bus_b.s_read_data <= 16'h1233 + {8'h00, bus_b.s_addr};
  end

  typedef struct {
    logic [1:0]  req, we, re;
    logic [7:0]  a0, a1;
    logic [15:0] w0, w1;
    logic [1:0]  grant;
    logic        wen, ren;
    logic [7:0]  saddr;
    logic [15:0] swd, rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_ack;
    logic [2:0]  acks[4];
    logic [15:0] rds[4];
    logic [1:0]  gids[4];
    int          cyc[4];
    int          n;
    logic [2:0]  w_ack[3];
    logic [2:0]  w_exp[3];
    logic [15:0] w_rd[3];
    logic [15:0] w_rexp[3];

    total = 0;
    bad   = 0;
    //           req    we     re     a0     a1     w0        w1        g  wen ren saddr  swd       rdata
    vecs[0] = '{2'b01, 2'b00, 2'b01, 8'h01, 8'h00, 16'h0000, 16'h0000, 0, 0, 1, 8'h01, 16'h0000, 16'h1234};
    vecs[1] = '{2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 16'h0000, 16'hBEEF, 1, 1, 0, 8'h02, 16'hBEEF, 16'h1234};
    vecs[2] = '{2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 16'h0000, 16'h0000, 0, 0, 1, 8'h10, 16'h0000, 16'h1243};
    vecs[3] = '{2'b11, 2'b00, 2'b11, 8'h10, 8'h20, 16'h0000, 16'h0000, 1, 0, 1, 8'h20, 16'h0000, 16'h1253};
    vecs[4] = '{2'b01, 2'b01, 2'b01, 8'h30, 8'h00, 16'hA5A5, 16'h0000, 0, 1, 0, 8'h30, 16'hA5A5, 16'h1253};
    vecs[5] = '{2'b10, 2'b00, 2'b00, 8'h00, 8'h40, 16'h0000, 16'h0F0F, 1, 0, 0, 8'h40, 16'h0F0F, 16'h1253};
    vecs[6] = '{2'b10, 2'b00, 2'b10, 8'h00, 8'h05, 16'h0000, 16'h0000, 1, 0, 1, 8'h05, 16'h0000, 16'h1238};
    vecs[7] = '{2'b01, 2'b01, 2'b00, 8'h07, 8'h00, 16'h1357, 16'h0000, 0, 1, 0, 8'h07, 16'h1357, 16'h1238};

    reset_n = 1'b0;
    bus_a.m_req = '0; bus_a.m_we = '0; bus_a.m_re = '0; bus_a.m_addr = '0; bus_a.m_wdata = '0;
    bus_b.m_req = '0; bus_b.m_we = '0; bus_b.m_re = '0; bus_b.m_addr = '0; bus_b.m_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_ack",   32'(bus_a.m_ack), 32'(0));
    check("rst_rdata", 32'(bus_a.m_rdata), 32'(0));
    check("rst_saddr", 32'(bus_a.s_addr), 32'(0));
    check("rst_swd",   32'(bus_a.s_write_data), 32'(0));
    check("rst_strb",  32'({bus_a.s_write_en, bus_a.s_read_en}), 32'(0));
    check("rst_gid",   32'(bus_a.grant_id), 32'(0));
    reset_n = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      bus_a.m_req   = vecs[v].req;
      bus_a.m_we    = vecs[v].we;
      bus_a.m_re    = vecs[v].re;
      bus_a.m_addr  = {vecs[v].a1, vecs[v].a0};
      bus_a.m_wdata = {vecs[v].w1, vecs[v].w0};
      exp_ack = 2'b01 << vecs[v].grant;
      @(posedge clock); @(negedge clock);
      check($sformatf("v%0d_issue_gid", v), 32'(bus_a.grant_id), 32'(vecs[v].grant));
      check($sformatf("v%0d_issue_wen", v), 32'(bus_a.s_write_en), 32'(vecs[v].wen));
      check($sformatf("v%0d_issue_ren", v), 32'(bus_a.s_read_en), 32'(vecs[v].ren));
      check($sformatf("v%0d_issue_addr", v), 32'(bus_a.s_addr), 32'(vecs[v].saddr));
      check($sformatf("v%0d_issue_wd", v), 32'(bus_a.s_write_data), 32'(vecs[v].swd));
      check($sformatf("v%0d_issue_ack", v), 32'(bus_a.m_ack), 32'(0));
      @(posedge clock); @(negedge clock);
      check($sformatf("v%0d_wait_strb", v), 32'({bus_a.s_write_en, bus_a.s_read_en}), 32'(0));
      check($sformatf("v%0d_wait_ack", v), 32'(bus_a.m_ack), 32'(0));
      check($sformatf("v%0d_wait_addr", v), 32'(bus_a.s_addr), 32'(vecs[v].saddr));
      @(posedge clock); @(negedge clock);
      check($sformatf("v%0d_ack", v), 32'(bus_a.m_ack), 32'(exp_ack));
      check($sformatf("v%0d_rdata", v), 32'(bus_a.m_rdata), 32'(vecs[v].rdata));
      bus_a.m_req = '0;
      @(posedge clock); @(negedge clock);
      check($sformatf("v%0d_idle_ack", v), 32'(bus_a.m_ack), 32'(0));
    end

    // Reset during WAIT of a read aborts without an ack.
    bus_a.m_req = 2'b01; bus_a.m_we = '0; bus_a.m_re = 2'b01;
    bus_a.m_addr = {8'h00, 8'h01}; bus_a.m_wdata = '0;
    @(posedge clock); @(negedge clock);
    check("abort_issue_ren", 32'(bus_a.s_read_en), 32'(1));
    @(posedge clock); @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_ack",   32'(bus_a.m_ack), 32'(0));
    check("abort_rdata", 32'(bus_a.m_rdata), 32'(0));
    check("abort_saddr", 32'(bus_a.s_addr), 32'(0));
    check("abort_swd",   32'(bus_a.s_write_data), 32'(0));
    check("abort_strb",  32'({bus_a.s_write_en, bus_a.s_read_en}), 32'(0));
    check("abort_gid",   32'(bus_a.grant_id), 32'(0));
    bus_a.m_req = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); @(negedge clock);
      check($sformatf("abort_noack_c%0d", c), 32'(bus_a.m_ack), 32'(0));
    end

    // Continuous contention after reset: grants 0,1,0,1 four cycles apart.
    bus_a.m_req = 2'b11; bus_a.m_we = '0; bus_a.m_re = 2'b11;
    bus_a.m_addr = {8'h22, 8'h11};
    n = 0;
    for (int c = 0; c < 24 && n < 4; c++) begin
      @(posedge clock); @(negedge clock);
      if (bus_a.m_ack != '0) begin
        acks[n] = {1'b0, bus_a.m_ack};
        rds[n]  = bus_a.m_rdata;
        gids[n] = bus_a.grant_id;
        cyc[n]  = c;
        n++;
      end
    end
    bus_a.m_req = '0;
    check("cont_count", 32'(n), 32'(4));
    for (int j = 0; j < n; j++) begin
      check($sformatf("cont_ack%0d", j), 32'(acks[j]), (j % 2 == 0) ? 32'(1) : 32'(2));
      check($sformatf("cont_gid%0d", j), 32'(gids[j]), 32'(j % 2));
      check($sformatf("cont_rdata%0d", j), 32'(rds[j]), (j % 2 == 0) ? 32'h1244 : 32'h1255);
      if (j == 0) check("cont_first_lat", 32'(cyc[0]), 32'(2));
      else check($sformatf("cont_gap%0d", j), 32'(cyc[j] - cyc[j-1]), 32'(4));
    end

    // Three masters: 1 and 2 request, then 0 and 2 -> grants 1, 2, 0.
    w_exp[0] = 3'b010; w_exp[1] = 3'b100; w_exp[2] = 3'b001;
    w_rexp[0] = 16'h1235; w_rexp[1] = 16'h1236; w_rexp[2] = 16'h1234;
    bus_b.m_addr = {8'h03, 8'h02, 8'h01};
    bus_b.m_re = 3'b111; bus_b.m_we = '0;
    bus_b.m_req = 3'b110;
    n = 0;
    for (int c = 0; c < 24 && n < 3; c++) begin
      @(posedge clock); @(negedge clock);
      if (bus_b.m_ack != '0) begin
        w_ack[n] = bus_b.m_ack;
        w_rd[n]  = bus_b.m_rdata;
        bus_b.m_req = bus_b.m_req & ~bus_b.m_ack;
        if (n == 0) bus_b.m_req = bus_b.m_req | 3'b001;
        n++;
      end
    end
    bus_b.m_req = '0;
    check("wrap_count", 32'(n), 32'(3));
    for (int j = 0; j < n; j++) begin
      check($sformatf("wrap_ack%0d", j), 32'(w_ack[j]), 32'(w_exp[j]));
      check($sformatf("wrap_rdata%0d", j), 32'(w_rd[j]), 32'(w_rexp[j]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
